// File: rtl/branch_predictor_if.sv
// Bundle between the ID/EX pipeline stages and the branch predictor.
// The slave modport is the predictor's view; the master modport is the
// pipeline's view (drives the ID/EX inputs and consumes the outputs).
//   ID_Branch_i, ID_Stall_i, ID_PC_i, ID_immExtended_i : ID-stage inputs
//   EX_Taken_i                                         : EX-stage outcome
//   Predict_o, Flush_o, PC_Correct_o                   : prediction / redirect
//   branch_cnt_o, mispredict_cnt_o                     : perf counters
interface branch_predictor_if #(
  parameter int COUNT_W = 32
);
  logic               ID_Branch_i;
  logic               ID_Stall_i;
  logic [31:0]        ID_PC_i;
  logic [31:0]        ID_immExtended_i;
  logic               EX_Taken_i;
  logic               Predict_o;
  logic               Flush_o;
  logic [31:0]        PC_Correct_o;
  logic [COUNT_W-1:0] branch_cnt_o;
  logic [COUNT_W-1:0] mispredict_cnt_o;

  modport slave (
    input  ID_Branch_i, ID_Stall_i, ID_PC_i, ID_immExtended_i, EX_Taken_i,
    output Predict_o, Flush_o, PC_Correct_o, branch_cnt_o, mispredict_cnt_o
  );

  modport master (
    output ID_Branch_i, ID_Stall_i, ID_PC_i, ID_immExtended_i, EX_Taken_i,
    input  Predict_o, Flush_o, PC_Correct_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic 2-bit saturating-counter branch predictor with EX-stage resolver.
// Predicts the branch in ID from a PC-indexed counter table, carries the
// prediction into EX, flags mispredicts there (flush + corrected PC), trains
// the table and maintains branch / mispredict perf counters.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bp    : branch_predictor_if.slave (ID/EX inputs, prediction, redirect, counters)
module branch_predictor #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] INIT_STATE = 2'b11,
  parameter int         COUNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_table_r [ENTRIES];
  logic [INDEX_BITS-1:0] idx_s;
  logic                  predict_s;
  logic                  mis_s;
  logic                  flush_s;

  logic                  ex_valid_r;
  logic                  ex_pred_r;
  logic [INDEX_BITS-1:0] ex_idx_r;
  logic [31:0]           ex_pc4_r;
  logic [31:0]           ex_tgt_r;
  logic [COUNT_W-1:0]    branch_cnt_r;
  logic [COUNT_W-1:0]    mispredict_cnt_r;

  // Saturating 2-bit counter step toward the actual outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    logic [1:0] next_state;
    case ({taken, state})
      3'b1_11: next_state = 2'b11;
      3'b0_00: next_state = 2'b00;
      3'b1_00, 3'b1_01, 3'b1_10: next_state = state + 2'd1;
      3'b0_01, 3'b0_10, 3'b0_11: next_state = state - 2'd1;
      default: next_state = state;
    endcase
    return next_state;
  endfunction

  // Table lookup for ID and mispredict resolution for EX.
  always_comb begin
    idx_s     = bp.ID_PC_i[INDEX_BITS+1:2];
    // The table is only written at the clock edge, so a same-cycle training
    // of this index is not yet visible here: the old value is used.
    predict_s = bp.ID_Branch_i & ctr_table_r[idx_s][1];
    mis_s     = ex_valid_r & (ex_pred_r != bp.EX_Taken_i);
    flush_s   = mis_s & ~rst_i;
  end

  // Drive the interface outputs.
  always_comb begin
    bp.Predict_o        = predict_s;
    bp.Flush_o          = flush_s;
    bp.branch_cnt_o     = branch_cnt_r;
    bp.mispredict_cnt_o = mispredict_cnt_r;
    if (ex_valid_r) begin
      // A taken prediction was wrong -> fall through; otherwise go to target.
      bp.PC_Correct_o = ex_pred_r ? ex_pc4_r : ex_tgt_r;
    end else begin
      bp.PC_Correct_o = 32'h0000_0000;
    end
  end

  // Counter table, EX slot and perf counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_table_r[i] <= INIT_STATE;
      end
      ex_valid_r       <= 1'b0;
      ex_pred_r        <= 1'b0;
      ex_idx_r         <= '0;
      ex_pc4_r         <= 32'h0000_0000;
      ex_tgt_r         <= 32'h0000_0000;
      branch_cnt_r     <= '0;
      mispredict_cnt_r <= '0;
    end else begin
      // Resolve and train the branch in EX; this happens even under stall.
      if (ex_valid_r) begin
        ctr_table_r[ex_idx_r] <= sat_update(ctr_table_r[ex_idx_r], bp.EX_Taken_i);
        branch_cnt_r          <= branch_cnt_r + COUNT_W'(1);
        if (mis_s) begin
          mispredict_cnt_r <= mispredict_cnt_r + COUNT_W'(1);
        end else begin
          mispredict_cnt_r <= mispredict_cnt_r;
        end
      end else begin
        branch_cnt_r     <= branch_cnt_r;
        mispredict_cnt_r <= mispredict_cnt_r;
      end

      // Flush outranks stall: the ID instruction is wrong-path either way.
      if (flush_s) begin
        ex_valid_r <= 1'b0;
      end else if (bp.ID_Stall_i) begin
        ex_valid_r <= 1'b0;
      end else begin
        ex_valid_r <= bp.ID_Branch_i;
        ex_pred_r  <= predict_s;
        ex_idx_r   <= idx_s;
        ex_pc4_r   <= bp.ID_PC_i + 32'd4;
        ex_tgt_r   <= bp.ID_PC_i + (bp.ID_immExtended_i << 1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  branch_predictor_if #(.COUNT_W(32)) bp_if ();

  branch_predictor #(
    .INDEX_BITS (4),
    .INIT_STATE (2'b11),
    .COUNT_W    (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp    (bp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic br, input logic stall, input logic [31:0] pc,
                          input logic [31:0] imm, input logic taken);
    bp_if.ID_Branch_i      = br;
    bp_if.ID_Stall_i       = stall;
    bp_if.ID_PC_i          = pc;
    bp_if.ID_immExtended_i = imm;
    bp_if.EX_Taken_i       = taken;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b exp=0", bp_if.Flush_o); end
    rst = 1'b0;
    tick();
    n_vec++; if (bp_if.PC_Correct_o !== 32'h0) begin n_bad++; $display("FAIL reset_pcc got=%h exp=0", bp_if.PC_Correct_o); end
    n_vec++; if (bp_if.branch_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_bcnt got=%0d exp=0", bp_if.branch_cnt_o); end
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_mcnt got=%0d exp=0", bp_if.mispredict_cnt_o); end
    drive_id(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
    n_vec++; if (bp_if.Predict_o !== 1'b1) begin n_bad++; $display("FAIL reset_predict got=%b exp=1", bp_if.Predict_o); end
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Scenario 1: first branch, strong-T, not taken.
  task automatic test_first_mispredict();
    drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
    n_vec++; if (bp_if.Predict_o !== 1'b1) begin n_bad++; $display("FAIL t1_predict got=%b exp=1", bp_if.Predict_o); end
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL t1_flush got=%b exp=1", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h14) begin n_bad++; $display("FAIL t1_pcc got=%h exp=14", bp_if.PC_Correct_o); end
    tick();
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL t1_flush_clr got=%b exp=0", bp_if.Flush_o); end
    n_vec++; if (bp_if.branch_cnt_o !== 32'd1) begin n_bad++; $display("FAIL t1_bcnt got=%0d exp=1", bp_if.branch_cnt_o); end
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd1) begin n_bad++; $display("FAIL t1_mcnt got=%0d exp=1", bp_if.mispredict_cnt_o); end
  endtask

  // Scenario 2: three more not-taken; table 10 -> 01 -> 00 -> 00.
  task automatic test_saturate_low();
    logic [2:0] exp_pred;
    exp_pred = 3'b001;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
      n_vec++; if (bp_if.Predict_o !== exp_pred[i]) begin n_bad++; $display("FAIL t2_predict[%0d] got=%b exp=%b", i, bp_if.Predict_o, exp_pred[i]); end
      tick();
      drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      n_vec++; if (bp_if.Flush_o !== exp_pred[i]) begin n_bad++; $display("FAIL t2_flush[%0d] got=%b exp=%b", i, bp_if.Flush_o, exp_pred[i]); end
      tick();
    end
    n_vec++; if (bp_if.branch_cnt_o !== 32'd4) begin n_bad++; $display("FAIL t2_bcnt got=%0d exp=4", bp_if.branch_cnt_o); end
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd2) begin n_bad++; $display("FAIL t2_mcnt got=%0d exp=2", bp_if.mispredict_cnt_o); end
  endtask

  // Scenario 3: counter at 00, taken twice; 00 -> 01 -> 10.
  task automatic test_taken_from_nt();
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
      n_vec++; if (bp_if.Predict_o !== 1'b0) begin n_bad++; $display("FAIL t3_predict[%0d] got=%b exp=0", i, bp_if.Predict_o); end
      tick();
      drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL t3_flush[%0d] got=%b exp=1", i, bp_if.Flush_o); end
      n_vec++; if (bp_if.PC_Correct_o !== 32'h20) begin n_bad++; $display("FAIL t3_pcc[%0d] got=%h exp=20", i, bp_if.PC_Correct_o); end
      tick();
    end
    drive_id(1'b1, 1'b1, 32'h10, 32'h0, 1'b0);
    n_vec++; if (bp_if.Predict_o !== 1'b1) begin n_bad++; $display("FAIL t3_table10 got=%b exp=1", bp_if.Predict_o); end
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd4) begin n_bad++; $display("FAIL t3_mcnt got=%0d exp=4", bp_if.mispredict_cnt_o); end
  endtask

  // Scenario 4: stall in ID while a mispredicting branch resolves in EX.
  task automatic test_stall_flush();
    drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
    tick();
    drive_id(1'b1, 1'b1, 32'h50, 32'd8, 1'b0);
    n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL t4_flush got=%b exp=1", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h14) begin n_bad++; $display("FAIL t4_pcc got=%h exp=14", bp_if.PC_Correct_o); end
    tick();
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL t4_exvalid_flush got=%b exp=0", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h0) begin n_bad++; $display("FAIL t4_exvalid_pcc got=%h exp=0", bp_if.PC_Correct_o); end
    n_vec++; if (bp_if.branch_cnt_o !== 32'd7) begin n_bad++; $display("FAIL t4_bcnt got=%0d exp=7", bp_if.branch_cnt_o); end
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Scenario 5: back-to-back branches, read/write collision and independence.
  task automatic test_back_to_back();
    // table[4] = 01: first predicts NT, resolves taken; second reads old 01.
    drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
    n_vec++; if (bp_if.Predict_o !== 1'b0) begin n_bad++; $display("FAIL t5_pred1 got=%b exp=0", bp_if.Predict_o); end
    tick();
    drive_id(1'b1, 1'b0, 32'h50, 32'd8, 1'b1);
    n_vec++; if (bp_if.Predict_o !== 1'b0) begin n_bad++; $display("FAIL t5_collide got=%b exp=0", bp_if.Predict_o); end
    n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL t5_flush got=%b exp=1", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h20) begin n_bad++; $display("FAIL t5_pcc got=%h exp=20", bp_if.PC_Correct_o); end
    tick();
    drive_id(1'b1, 1'b1, 32'h50, 32'h0, 1'b0);
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL t5_wrongpath got=%b exp=0", bp_if.Flush_o); end
    n_vec++; if (bp_if.Predict_o !== 1'b1) begin n_bad++; $display("FAIL t5_newval got=%b exp=1", bp_if.Predict_o); end
    // Two distinct branches: 0x10 taken (correct), 0x14 not taken (mispredict).
    drive_id(1'b1, 1'b0, 32'h10, 32'd8, 1'b0);
    tick();
    drive_id(1'b1, 1'b0, 32'h14, 32'd4, 1'b1);
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL t5_b1_flush got=%b exp=0", bp_if.Flush_o); end
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL t5_b2_flush got=%b exp=1", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h18) begin n_bad++; $display("FAIL t5_b2_pcc got=%h exp=18", bp_if.PC_Correct_o); end
    tick();
    n_vec++; if (bp_if.branch_cnt_o !== 32'd10) begin n_bad++; $display("FAIL t5_bcnt got=%0d exp=10", bp_if.branch_cnt_o); end
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd7) begin n_bad++; $display("FAIL t5_mcnt got=%0d exp=7", bp_if.mispredict_cnt_o); end
  endtask

  // PC + 4 wraps modulo 2^32.
  task automatic test_wrap();
    drive_id(1'b1, 1'b0, 32'hFFFF_FFFC, 32'd8, 1'b0);
    tick();
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_vec++; if (bp_if.Flush_o !== 1'b1) begin n_bad++; $display("FAIL wrap_flush got=%b exp=1", bp_if.Flush_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h0) begin n_bad++; $display("FAIL wrap_pcc got=%h exp=0", bp_if.PC_Correct_o); end
    tick();
  endtask

  // Scenario 6: reset while a mispredicting branch sits in EX.
  task automatic test_reset_midflight();
    // Drive table[6] down to 01 with two not-taken branches.
    for (int i = 0; i < 2; i++) begin
      drive_id(1'b1, 1'b0, 32'h18, 32'd8, 1'b0);
      tick();
      drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    drive_id(1'b1, 1'b0, 32'h18, 32'd8, 1'b0);
    n_vec++; if (bp_if.Predict_o !== 1'b0) begin n_bad++; $display("FAIL t6_pre_predict got=%b exp=0", bp_if.Predict_o); end
    tick();
    rst = 1'b1;
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_vec++; if (bp_if.Flush_o !== 1'b0) begin n_bad++; $display("FAIL t6_flush got=%b exp=0", bp_if.Flush_o); end
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (bp_if.branch_cnt_o !== 32'd0) begin n_bad++; $display("FAIL t6_bcnt got=%0d exp=0", bp_if.branch_cnt_o); end
    n_vec++; if (bp_if.mispredict_cnt_o !== 32'd0) begin n_bad++; $display("FAIL t6_mcnt got=%0d exp=0", bp_if.mispredict_cnt_o); end
    n_vec++; if (bp_if.PC_Correct_o !== 32'h0) begin n_bad++; $display("FAIL t6_pcc got=%h exp=0", bp_if.PC_Correct_o); end
    drive_id(1'b1, 1'b1, 32'h18, 32'h0, 1'b1);
    n_vec++; if (bp_if.Predict_o !== 1'b1) begin n_bad++; $display("FAIL t6_table_init got=%b exp=1", bp_if.Predict_o); end
    tick();
    n_vec++; if (bp_if.branch_cnt_o !== 32'd0) begin n_bad++; $display("FAIL t6_bcnt_after got=%0d exp=0", bp_if.branch_cnt_o); end
    drive_id(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    test_reset();
    test_first_mispredict();
    test_saturate_low();
    test_taken_from_nt();
    test_stall_flush();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
